// File: rtl/trunc_mult_seq.sv
// trunc_mult_seq: iterative truncated unsigned N x N multiplier returning the
// upper N bits of the product. One partial-product row is added per clock.
// Columns below weight 2^(N-K) are never formed; CORR*2^(N-K) is preloaded
// into the accumulator instead.
// Optional macro TRUNC_VAR_CORR_EN: each row also adds its column-(N-K-1)
// bit at weight 2^(N-K) (variable correction). Ignored when K=N.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready, x, y  : operand handshake (in_ready high only in IDLE)
//   out_valid/out_ready, z   : result handshake, z = upper N bits
//   busy                     : high while rows are being accumulated
module trunc_mult_seq #(
  parameter int N    = 4,
  parameter int K    = 2,
  parameter int CORR = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z,
  output logic         busy
);

  localparam int AW = 2 * N + 1;
  localparam int RW = (N > 2) ? $clog2(N) : 1;
  localparam logic [AW-1:0] ACC_INIT = AW'(CORR) << (N - K);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [RW-1:0] row_q, row_d;
  logic [N-1:0]  z_q, z_d;

  logic          accept;
  logic          last_row;
  logic [N-1:0]  x_mask;
  logic [N-1:0]  y_sh;
  logic          y_bit;
  logic [AW-1:0] pp;
  logic [AW-1:0] vc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      row_q <= '0;
      z_q   <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
      row_q <= row_d;
      z_q   <= z_d;
    end
  end

  assign accept   = in_valid & in_ready;
  assign last_row = (row_q == LAST_ROW);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last_row) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: in_ready  = 1'b1;
      RUN:  busy      = 1'b1;
      DONE: out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign z = z_q;

  // Row term: x bit j lands in column row+j; drop it when that
  // column sits below the retained window.
  always_comb begin
    x_mask = '0;
    for (int j = 0; j < N; j++) begin
      if (j + int'(row_q) >= N - K) x_mask[j] = x_q[j];
    end
    y_sh  = y_q >> row_q;
    y_bit = y_sh[0];
    pp    = y_bit ? (AW'(x_mask) << row_q) : '0;
  end

`ifdef TRUNC_VAR_CORR_EN
  // Column N-K-1 bit of this row, promoted to weight 2^(N-K).
  logic [N-1:0] x_sh;
  int           idx;
  always_comb begin
    vc   = '0;
    x_sh = '0;
    idx  = N - K - 1 - int'(row_q);
    if (K < N && idx >= 0) begin
      x_sh = x_q >> idx;
      if (x_sh[0] & y_bit) vc = AW'(1) << (N - K);
    end
  end
`else
  assign vc = '0;
`endif

  // Datapath next values
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    acc_d = acc_q;
    row_d = row_q;
    z_d   = z_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          x_d   = x;
          y_d   = y;
          acc_d = ACC_INIT;
          row_d = '0;
        end
      end
      RUN: begin
        acc_d = acc_q + pp + vc;
        if (last_row) begin
          row_d = '0;
          z_d   = acc_d[2*N-1:N];
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      DONE: ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trunc_mult_seq.sv
// Testbench for trunc_mult_seq: directed N=4 vector table over three
// parameter sets, reset abort, back-to-back throughput and N=8 random ops.
module tb_trunc_mult_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  // N=4 group: shared inputs, three parameter sets
  logic       in_valid4, out_ready4;
  logic [3:0] x4, y4;
  logic       ir4a, ir4b, ir4c, ov4a, ov4b, ov4c, bz4a, bz4b, bz4c;
  logic [3:0] z4a, z4b, z4c;

  // N=8 group
  logic       in_valid8, out_ready8;
  logic [7:0] x8, y8;
  logic       ir8a, ir8b, ir8c, ov8a, ov8b, ov8c, bz8a, bz8b, bz8c;
  logic [7:0] z8a, z8b, z8c;

  trunc_mult_seq #(.N(4), .K(2), .CORR(0)) u4a (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(ir4a),
    .x(x4), .y(y4), .out_valid(ov4a), .out_ready(out_ready4),
    .z(z4a), .busy(bz4a));
  trunc_mult_seq #(.N(4), .K(4), .CORR(0)) u4b (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(ir4b),
    .x(x4), .y(y4), .out_valid(ov4b), .out_ready(out_ready4),
    .z(z4b), .busy(bz4b));
  trunc_mult_seq #(.N(4), .K(2), .CORR(1)) u4c (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(ir4c),
    .x(x4), .y(y4), .out_valid(ov4c), .out_ready(out_ready4),
    .z(z4c), .busy(bz4c));

  trunc_mult_seq #(.N(8), .K(0), .CORR(0)) u8a (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(ir8a),
    .x(x8), .y(y8), .out_valid(ov8a), .out_ready(out_ready8),
    .z(z8a), .busy(bz8a));
  trunc_mult_seq #(.N(8), .K(3), .CORR(5)) u8b (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(ir8b),
    .x(x8), .y(y8), .out_valid(ov8b), .out_ready(out_ready8),
    .z(z8b), .busy(bz8b));
  trunc_mult_seq #(.N(8), .K(8), .CORR(3)) u8c (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(ir8c),
    .x(x8), .y(y8), .out_valid(ov8c), .out_ready(out_ready8),
    .z(z8c), .busy(bz8c));

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] zk2;
    logic [3:0] zk4;
    logic [3:0] zk2c1;
    logic [3:0] zk2v;
    logic [3:0] zk2c1v;
    int         stall;
  } vec_t;

  vec_t vec[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Column-sum reference of the truncated product
  function automatic int unsigned mdl(input int n, input int k,
                                      input int c, input int unsigned xv,
                                      input int unsigned yv);
    longint unsigned t;
    t = 0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        if (i + j >= n - k && xv[j] && yv[i])
          t += 64'(1) << (i + j);
`ifdef TRUNC_VAR_CORR_EN
    if (k < n)
      for (int i = 0; i < n; i++)
        if (n - k - 1 - i >= 0 && xv[n-k-1-i] && yv[i])
          t += 64'(1) << (n - k);
`endif
    t += longint'(c) << (n - k);
    return int'((t >> n) & ((64'(1) << n) - 1));
  endfunction

  task automatic op4(input logic [3:0] xa, input logic [3:0] ya,
                     input int stall, output logic [3:0] za,
                     output logic [3:0] zb, output logic [3:0] zc);
    int t;
    logic ok;
    in_valid4 = 1'b1;
    x4 = xa;
    y4 = ya;
    t = 0;
    while (!ir4a && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("accept4_wait", 32'(t < 50), 1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    x4 = ~xa;
    y4 = ~ya;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (!(bz4a && bz4b && bz4c) || ov4a || ov4b || ov4c ||
          ir4a || ir4b || ir4c) ok = 1'b0;
      @(posedge clk); #1;
    end
    if (!(ov4a && ov4b && ov4c) || bz4a || ir4a || ir4b || ir4c) ok = 1'b0;
    chk("run4_timing", 32'(ok), 1);
    za = z4a;
    zb = z4b;
    zc = z4c;
    ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (!ov4a || z4a !== za || z4b !== zb || z4c !== zc) ok = 1'b0;
    end
    chk("stall4_hold", 32'(ok), 1);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk("hs4_idle", {ov4a, ir4a, ov4b, ir4b, ov4c, ir4c}, 6'b010101);
  endtask

  task automatic op8(input logic [7:0] xa, input logic [7:0] ya,
                     input int stall);
    int t;
    logic ok;
    logic [7:0] za, zb, zc;
    in_valid8 = 1'b1;
    x8 = xa;
    y8 = ya;
    t = 0;
    while (!ir8a && t < 50) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    x8 = 8'($urandom);
    y8 = 8'($urandom);
    t = 0;
    while (!(ov8a && ov8b && ov8c) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("run8_latency", t, 8);
    za = z8a;
    zb = z8b;
    zc = z8c;
    ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (!ov8a || z8a !== za || z8b !== zb || z8c !== zc ||
          ir8b || ir8c || bz8b || bz8c) ok = 1'b0;
    end
    chk("stall8_hold", 32'(ok), 1);
    chk("z8_k0", z8a, mdl(8, 0, 0, xa, ya));
    chk("z8_k3", z8b, mdl(8, 3, 5, xa, ya));
    chk("z8_k8", z8c, mdl(8, 8, 3, xa, ya));
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    logic [3:0] za, zb, zc;
    logic [3:0] ek2, ek2c1;
    int cnt;

    //         x   y  k2 k4 c1 k2v c1v stall
    vec[0] = '{15, 15, 13, 14, 14, 14, 14, 3};
    vec[1] = '{ 8,  8,  4,  4,  4,  4,  4, 0};
    vec[2] = '{ 0, 13,  0,  0,  0,  0,  0, 1};
    vec[3] = '{ 3,  5,  0,  0,  1,  1,  1, 0};
    vec[4] = '{13, 11,  8,  8,  9,  9,  9, 2};
    vec[5] = '{ 7,  9,  3,  3,  4,  4,  4, 0};
    vec[6] = '{ 6, 10,  3,  3,  4,  3,  4, 1};
    vec[7] = '{15,  1,  0,  0,  1,  1,  1, 0};

    reset = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b0; x4 = '0; y4 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; x8 = '0; y8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state4", {ir4a, ov4a, bz4a, z4a, z4b, z4c}, {3'b100, 12'h000});
    chk("reset_state8", {ir8a, ov8a, bz8a, z8a}, {3'b100, 8'h00});
    #2 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
`ifdef TRUNC_VAR_CORR_EN
      ek2 = vec[i].zk2v;
      ek2c1 = vec[i].zk2c1v;
`else
      ek2 = vec[i].zk2;
      ek2c1 = vec[i].zk2c1;
`endif
      op4(vec[i].x, vec[i].y, vec[i].stall, za, zb, zc);
      chk($sformatf("z4_k2[%0d]", i), za, ek2);
      chk($sformatf("z4_k4[%0d]", i), zb, vec[i].zk4);
      chk($sformatf("z4_k2c1[%0d]", i), zc, ek2c1);
    end

    // Back-to-back: in_valid held, consecutive accepts are N+2 apart
    in_valid4 = 1'b1;
    x4 = 4'd8;
    y4 = 4'd8;
    out_ready4 = 1'b1;
    cnt = 0;
    while (!bz4a && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (bz4a && cnt < 50);
    while (!bz4a && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    chk("b2b_spacing", cnt, 6);
    in_valid4 = 1'b0;
    cnt = 0;
    while (!ov4a && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    chk("b2b_z", {z4a, z4b, z4c}, {4'd4, 4'd4, 4'd4});
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk("b2b_drain", {ir4a, ov4a}, 2'b10);

    // Abort two cycles into RUN
    in_valid4 = 1'b1;
    x4 = 4'd15;
    y4 = 4'd15;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_abort_busy", bz4a, 1);
    reset = 1'b1;
    #1;
    chk("abort_state", {ov4a, ir4a, bz4a, ov4b, ir4b, ov4c, ir4c},
        7'b0100101);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    op4(4'd3, 4'd5, 0, za, zb, zc);
    chk("after_abort_k4", zb, 0);
    chk("after_abort_k2", za, 0);
    chk("after_abort_k2c1", zc, 1);

    // N=8 corners then random with stalls
    op8(8'hFF, 8'hFF, 2);
    op8(8'h00, 8'hA5, 0);
    op8(8'h80, 8'h01, 1);
    for (int i = 0; i < 25; i++)
      op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
